// File: rtl/fir_coef_ctrl.sv
// Coefficient shadow bank with a halt/copy commit sequencer for a FIR datapath.
// Writes land in shadow registers; a commit halts the filter and streams all taps out.
module fir_coef_ctrl #(
    parameter int NUM_TAPS  = 16,
    parameter int DATA_W    = 12,
    parameter int ADDR_W    = 8,
    parameter int DRAIN_CYC = 2
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Cfg_load,
    input  logic [ADDR_W-1:0] Cfg_addr,
    input  logic [DATA_W-1:0] Cfg_value,
    input  logic [ADDR_W-1:0] Cfg_rd_addr,
    output logic [DATA_W-1:0] Cfg_rd_value,
    input  logic              Ext_hlt,
    output logic              Hlt,
    output logic              Coef_load,
    output logic [ADDR_W-1:0] Coef_addr,
    output logic [DATA_W-1:0] Coef_value,
    output logic              Busy,
    output logic              Commit_done,
    output logic              Err
);

    localparam int IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    localparam logic [ADDR_W-1:0] TAPS_ADDR   = ADDR_W'(NUM_TAPS);
    localparam logic [ADDR_W-1:0] ADDR_COMMIT = ADDR_W'(8'hF0);
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(8'hF1);
    localparam logic [ADDR_W-1:0] ADDR_CLR    = ADDR_W'(8'hF2);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_TAPS - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT    = CNT_W'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HALT,
        ST_COPY,
        ST_DONE
    } state_t;

    state_t              state_reg;
    logic [DATA_W-1:0]   shadow_reg [NUM_TAPS];
    logic [NUM_TAPS-1:0] shadow_we;
    logic [IDX_W-1:0]    idx_reg;
    logic [IDX_W-1:0]    idx_next;
    logic [CNT_W-1:0]    cnt_reg;
    logic                busy_reg;
    logic                err_reg;
    logic                coef_load_reg;
    logic [ADDR_W-1:0]   coef_addr_reg;
    logic [DATA_W-1:0]   coef_value_reg;
    logic                commit_done_reg;

    logic cfg_in_range;
    logic cfg_is_commit;
    logic cfg_is_clr;
    logic err_set;

    assign cfg_in_range  = (Cfg_addr < TAPS_ADDR);
    assign cfg_is_commit = (Cfg_addr == ADDR_COMMIT);
    assign cfg_is_clr    = (Cfg_addr == ADDR_CLR);
    assign err_set       = Cfg_load && (busy_reg || (!cfg_in_range && !cfg_is_commit));
    assign idx_next      = idx_reg + IDX_W'(1);

    // Shadow bank is frozen whenever the sequencer is away from IDLE.
    generate
        for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_shadow_we
            assign shadow_we[gi] = Cfg_load && (state_reg == ST_IDLE) && (Cfg_addr == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NUM_TAPS; i++) shadow_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                if (shadow_we[i]) shadow_reg[i] <= Cfg_value;
            end
        end
    end

    // Clear has priority, so 0xF2 works even while a commit is running.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            err_reg <= 1'b0;
        end else if (Cfg_load && cfg_is_clr) begin
            err_reg <= 1'b0;
        end else if (err_set) begin
            err_reg <= 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg       <= ST_IDLE;
            idx_reg         <= '0;
            cnt_reg         <= '0;
            busy_reg        <= 1'b0;
            coef_load_reg   <= 1'b0;
            coef_addr_reg   <= '0;
            coef_value_reg  <= '0;
            commit_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (Cfg_load && cfg_is_commit) begin
                        state_reg <= ST_HALT;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= '0;
                    end
                end
                ST_HALT: begin
                    if (cnt_reg == LAST_CNT) begin
                        state_reg      <= ST_COPY;
                        idx_reg        <= '0;
                        coef_load_reg  <= 1'b1;
                        coef_addr_reg  <= '0;
                        coef_value_reg <= shadow_reg[0];
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_COPY: begin
                    if (idx_reg == LAST_IDX) begin
                        state_reg       <= ST_DONE;
                        coef_load_reg   <= 1'b0;
                        coef_addr_reg   <= '0;
                        coef_value_reg  <= '0;
                        commit_done_reg <= 1'b1;
                    end else begin
                        idx_reg        <= idx_next;
                        coef_addr_reg  <= ADDR_W'(idx_next);
                        coef_value_reg <= shadow_reg[idx_next];
                    end
                end
                ST_DONE: begin
                    state_reg       <= ST_IDLE;
                    busy_reg        <= 1'b0;
                    commit_done_reg <= 1'b0;
                    idx_reg         <= '0;
                    cnt_reg         <= '0;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        Cfg_rd_value = '0;
        if (Cfg_rd_addr < TAPS_ADDR) begin
            Cfg_rd_value = shadow_reg[Cfg_rd_addr[IDX_W-1:0]];
        end else if (Cfg_rd_addr == ADDR_STATUS) begin
            Cfg_rd_value = {{(DATA_W-2){1'b0}}, err_reg, busy_reg};
        end
    end

    assign Hlt         = Ext_hlt | busy_reg;
    assign Busy        = busy_reg;
    assign Err         = err_reg;
    assign Coef_load   = coef_load_reg;
    assign Coef_addr   = coef_addr_reg;
    assign Coef_value  = coef_value_reg;
    assign Commit_done = commit_done_reg;

endmodule

// File: doc/fir_coef_ctrl.md
FIR_COEF_CTRL -- requirements
Module: fir_coef_ctrl

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 16, number of filter coefficients (2..64).
REQ-002 SHALL have parameter DATA_W, default 12, coefficient width.
REQ-003 SHALL have parameter ADDR_W, default 8, configuration address width.
REQ-004 SHALL have parameter DRAIN_CYC, default 2, halt cycles before copy (>=1).
REQ-005 SHALL have port Clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port Rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port Cfg_load  input  1  one-cycle write strobe, synchronous to Clk.
REQ-008 SHALL have port Cfg_addr  input  ADDR_W  write address.
REQ-009 SHALL have port Cfg_value  input  DATA_W  write data.
REQ-010 SHALL have port Cfg_rd_addr  input  ADDR_W  read-back address.
REQ-011 SHALL have port Cfg_rd_value  output  DATA_W  read-back data.
REQ-012 SHALL have port Ext_hlt  input  1  external halt request.
REQ-013 SHALL have port Hlt  output  1  halt to filter datapath.
REQ-014 SHALL have port Coef_load  output  1  coefficient write strobe to filter.
REQ-015 SHALL have port Coef_addr  output  ADDR_W  coefficient index to filter.
REQ-016 SHALL have port Coef_value  output  DATA_W  coefficient data to filter.
REQ-017 SHALL have port Busy  output  1  commit sequence in progress.
REQ-018 SHALL have port Commit_done  output  1  one-cycle pulse at end of commit.
REQ-019 SHALL have port Err  output  1  sticky error flag.

Function
REQ-020 SHALL hold NUM_TAPS x DATA_W shadow registers; Cfg_load with Cfg_addr < NUM_TAPS and state IDLE writes shadow[Cfg_addr] at that edge.
REQ-021 SHALL decode 0xF0 = commit (data ignored), 0xF2 = clear Err (data ignored); all other addresses >= NUM_TAPS ignored and set Err.
REQ-022 SHALL, while Busy, ignore any Cfg_load (shadow, commit, or other) and set Err; exception: 0xF2 clears Err in any state.
REQ-023 SHALL implement FSM IDLE -> HALT -> COPY -> DONE -> IDLE.
REQ-024 IDLE: commit strobe at edge k enters HALT at edge k; Busy=1 from cycle after k.
REQ-025 HALT: counter runs DRAIN_CYC cycles, then enters COPY.
REQ-026 COPY: index i = 0..NUM_TAPS-1, one per cycle; Coef_load=1, Coef_addr=i, Coef_value=shadow[i], all registered; enters DONE after i = NUM_TAPS-1.
REQ-027 DONE: one cycle; Commit_done=1; returns to IDLE.
REQ-028 Busy SHALL be 1 in HALT, COPY, DONE: exactly DRAIN_CYC+NUM_TAPS+1 cycles per commit.
REQ-029 Hlt SHALL equal Ext_hlt OR Busy; Ext_hlt does not stall the FSM.
REQ-030 Coef_load SHALL be 0 outside COPY; Coef_addr/Coef_value SHALL be 0 when Coef_load=0.
REQ-031 Cfg_rd_value (combinational) SHALL be shadow[Cfg_rd_addr] for addr < NUM_TAPS, {0..., Err, Busy} at 0xF1, else 0.
REQ-032 Commit and 0xF2 in the same cycle is impossible (single address); Err set and clear in same cycle: clear wins.
REQ-033 Shadow reads during COPY SHALL return the committed values (shadow frozen while Busy).

Reset
REQ-034 Rst_n low SHALL asynchronously force state IDLE, all shadow registers 0, counters 0, Busy, Coef_load, Coef_addr, Coef_value, Commit_done, Err = 0; Hlt = Ext_hlt.
REQ-035 Reset mid-COPY SHALL abort with no resume; filter may hold a partial set; a fresh commit is required.

Verification
REQ-036 Write shadow[0..15]=0x001..0x010, commit, NUM_TAPS=16, DRAIN_CYC=2 -> Hlt=1 for 19 cycles, Coef_load for 16 cycles with addr 0..15 / data 0x001..0x010, Commit_done pulse on 19th cycle.
REQ-037 Cfg_load addr 0x20 in IDLE -> Err=1, shadow unchanged; then 0xF2 -> Err=0; read 0xF1 -> 0x000.
REQ-038 Write shadow[3]=0xABC during COPY -> ignored, Err=1, Coef_value for index 3 = previous value, read shadow[3] unchanged.
REQ-039 Second commit during HALT -> ignored, Err=1, Busy length still 19 cycles, single Commit_done.
REQ-040 Rst_n low at COPY index 7 -> Busy, Coef_load, Hlt (Ext_hlt=0) drop to 0 immediately, shadow reads 0.
REQ-041 Ext_hlt=1 throughout idle and commit -> Hlt=1 continuously, commit timing identical to REQ-036.
